// File: rtl/vga_scanout_if.sv
// vga_scanout_if: frame_buffer read port and buffer-swap strobe between scanout and frame buffer.
interface vga_scanout_if #(
    parameter int ADDR_WIDTH = 19
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  read_data;
    logic                  swap;
    modport master (output read_addr, output swap, input read_data);
    modport slave  (input read_addr, input swap, output read_data);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing, frame_buffer address walk, 2-stage output pipeline and swap pulse.
// Optional 1-pixel alignment outline when VGA_SCANOUT_BORDER_EN is defined.
module vga_scanout #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int HOR_FRONT_PORCH   = 16,
    parameter int HOR_SYNC_PIXELS   = 96,
    parameter int HOR_BACK_PORCH    = 48,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int VER_FRONT_PORCH   = 10,
    parameter int VER_SYNC_PIXELS   = 2,
    parameter int VER_BACK_PORCH    = 33,
    parameter int SYNC_ACTIVE_LOW   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_scanout_if.master        fb,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_de,
    output logic                 video_pixel
);
    localparam int HOR_TOTAL_PIXELS = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PIXELS + HOR_BACK_PORCH;
    localparam int VER_TOTAL_PIXELS = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PIXELS + VER_BACK_PORCH;
    localparam int HW = $clog2(HOR_TOTAL_PIXELS);
    localparam int VW = $clog2(VER_TOTAL_PIXELS);
    localparam logic [HW-1:0] H_LAST = HW'(HOR_TOTAL_PIXELS - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(HOR_ACTIVE_PIXELS);
    localparam logic [HW-1:0] HS_BEG = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [HW-1:0] HS_END = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PIXELS);
    localparam logic [VW-1:0] V_LAST = VW'(VER_TOTAL_PIXELS - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(VER_ACTIVE_PIXELS);
    localparam logic [VW-1:0] V_ACT_M1 = VW'(VER_ACTIVE_PIXELS - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [VW-1:0] VS_END = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PIXELS);
    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW != 0;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic h_wrap, active, hs_raw, vs_raw;
    logic active_d1, hs_d1, vs_d1, pix;

    always_comb begin
        h_wrap = h_cnt == H_LAST;
        active = h_cnt < H_ACT && v_cnt < V_ACT;
        hs_raw = h_cnt >= HS_BEG && h_cnt < HS_END;
        vs_raw = v_cnt >= VS_BEG && v_cnt < VS_END;
    end

`ifdef VGA_SCANOUT_BORDER_EN
    localparam logic [HW-1:0] H_ACT_M1 = HW'(HOR_ACTIVE_PIXELS - 1);
    logic border, border_d1;
    always_comb border = active && (h_cnt == '0 || h_cnt == H_ACT_M1 || v_cnt == '0 || v_cnt == V_ACT_M1);
    always_ff @(posedge clk) border_d1 <= rst ? 1'b0 : border;
    assign pix = active_d1 & (fb.read_data | border_d1);
`else
    assign pix = fb.read_data & active_d1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            fb.read_addr <= '0;
            fb.swap      <= 1'b0;
            active_d1    <= 1'b0;
            hs_d1        <= 1'b0;
            vs_d1        <= 1'b0;
            hsync        <= SYNC_OFF;
            vsync        <= SYNC_OFF;
            video_de     <= 1'b0;
            video_pixel  <= 1'b0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap)
                v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
            // address restarts as the counters enter the first blanking line
            fb.read_addr <= (h_wrap && v_cnt == V_ACT_M1) ? '0 :
                            active ? fb.read_addr + 1'b1 : fb.read_addr;
            fb.swap      <= h_cnt == '0 && v_cnt == V_ACT;
            active_d1    <= active;
            hs_d1        <= hs_raw;
            vs_d1        <= vs_raw;
            hsync        <= hs_d1 ^ SYNC_OFF;
            vsync        <= vs_d1 ^ SYNC_OFF;
            video_de     <= active_d1;
            video_pixel  <= pix;
        end
    end
endmodule
